// File: rtl/emulador_joypad.sv
// Console-side 3/6-button joypad emulator: syncs Select, tracks the falling-edge phase, drives the pad pins.
// Define JOYPAD_6BOTOES_EN for the 6-button pad; without it the block behaves as a 3-button pad.
module emulador_joypad #(
  parameter int TIMEOUT_CICLOS = 75000
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        Select,
  input  logic [11:0] Botoes,
  output logic        Pino1,
  output logic        Pino2,
  output logic        Pino3,
  output logic        Pino4,
  output logic        Pino6,
  output logic        Pino9,
  output logic [2:0]  Fase
);

  localparam logic [2:0] FASE_ID  = 3'd3;
  localparam logic [2:0] FASE_MAX = 3'd4;

  logic       sel1_q, sel2_q;
  logic [5:0] pinos_q, pinos_d;

  // Pin order {Pino1, Pino2, Pino3, Pino4, Pino6, Pino9}; active-low buttons.
  function automatic logic [5:0] mapa(input logic sel, input logic [2:0] f, input logic [11:0] b);
    logic [5:0] p;
    if (sel) begin
      if (f == FASE_ID) p = {~b[10], ~b[9], ~b[8], ~b[11], ~b[5], ~b[6]};
      else              p = {~b[0], ~b[1], ~b[2], ~b[3], ~b[5], ~b[6]};
    end else begin
      case (f)
        FASE_ID:  p = {4'b0000, ~b[4], ~b[7]};
        FASE_MAX: p = {4'b1111, ~b[4], ~b[7]};
        default:  p = {~b[0], ~b[1], 2'b00, ~b[4], ~b[7]};
      endcase
    end
    return p;
  endfunction

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      sel1_q  <= 1'b1;
      sel2_q  <= 1'b1;
      pinos_q <= '1;
    end else begin
      sel1_q  <= Select;
      sel2_q  <= sel1_q;
      pinos_q <= pinos_d;
    end
  end

`ifdef JOYPAD_6BOTOES_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  logic          sel3_q;
  logic [2:0]    fase_q, fase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borda, borda_desc, expira;

  // A falling edge coincident with the timeout restarts the sequence at phase 1.
  always_comb begin
    borda      = sel2_q ^ sel3_q;
    borda_desc = sel3_q & ~sel2_q;
    expira     = (cnt_q == CW'(TIMEOUT_CICLOS - 1));
    cnt_d      = cnt_q;
    if (borda)
      cnt_d = '0;
    else if (cnt_q != CW'(TIMEOUT_CICLOS))
      cnt_d = cnt_q + CW'(1);
    fase_d = expira ? 3'd0 : fase_q;
    if (borda_desc && (fase_d != FASE_MAX))
      fase_d = fase_d + 3'd1;
    pinos_d = mapa(sel2_q, fase_d, Botoes);
  end

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      sel3_q <= 1'b1;
      fase_q <= 3'd0;
      cnt_q  <= '0;
    end else begin
      sel3_q <= sel2_q;
      fase_q <= fase_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Fase = fase_q;
`else
  always_comb begin
    pinos_d = mapa(sel2_q, 3'd0, Botoes);
  end

  assign Fase = 3'd0;
`endif

  assign {Pino1, Pino2, Pino3, Pino4, Pino6, Pino9} = pinos_q;

endmodule
